commit_trace_encoder: RTL and testbench
=======================================

Name: commit_trace_encoder

Overview:
- On-chip transmitter for the per-cycle commit trace: register writeback, data-memory load/store and halt.
- Samples the writeback and data-memory event signals every cycle and buffers the events in a FIFO.
- Serialises events as 16-bit word records over a valid/ready stream. An external sink (trace port, UART bridge, or bench monitor) can rebuild the REG/LOAD/STORE/halt trace from them.
- Sits at the cpu top level, fed from the writeback stage and the data-memory port.

Parameters:
- FIFO_DEPTH, 8, number of event entries; power of 2, ≥2.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- ev_pc  in  16  PC associated with this cycle's events
- rf_we  in  1  register file written this cycle
- rf_waddr  in  4  destination register
- rf_wdata  in  16  writeback data
- mem_en  in  1  data-memory access this cycle
- mem_wr  in  1  access is a write
- mem_addr  in  16  data-memory address
- mem_wdata  in  16  store data
- mem_rdata  in  16  load data
- halt  in  1  halt reached memory/writeback stage
- tr_data  out  16  trace word
- tr_valid  out  1  tr_data valid
- tr_ready  in  1  sink accepts word
- tr_last  out  1  current word is the last word of its record
- overflow  out  1  sticky: at least one event was dropped
- drop_count  out  16  dropped event-cycles, saturating at 0xFFFF
- done  out  1  halt record fully sent

Behaviour:
- Reset (rst_n=0 at posedge clk) values:
  - tr_valid=0, tr_data=0, tr_last=0, overflow=0, drop_count=0, done=0.
  - FIFO empty, counters 0, state IDLE.
  - Reset mid-record abandons the record; no partial words are emitted afterwards.
- Event decode, per cycle with rst_n=1 and state≠DONE:
  - REG = rf_we.
  - LOAD = mem_en & ~mem_wr.
  - STORE = mem_en & mem_wr.
- Push rules:
  - Up to 2 entries are pushed per cycle, REG first, then LOAD/STORE.
  - If free slots < number of events this cycle, all of that cycle's events are dropped: drop_count++ (saturating), overflow=1.
  - A FIFO pop in the same cycle does not create space for that cycle's push.
- Counters:
  - cycle_count (16-bit, wrapping) increments every cycle out of reset; the first cycle after reset = 1.
  - inst_count (16-bit, wrapping) increments when halt | rf_we | (mem_en & mem_wr).
  - Both counters include the halt cycle.
- Halt handling:
  - Halt is never dropped. On the first halt cycle, the final inst_count and cycle_count are latched into a dedicated halt register (not the FIFO).
  - All later inputs are ignored.
- Record formats (words in order):
  - REG: 0x100r (r = rf_waddr), wdata.
  - LOAD: 0x2000, addr, rdata.
  - STORE: 0x3000, addr, wdata.
  - HALT: 0xF000, inst_count, cycle_count.
- FSM:
  - IDLE: go to SEND when the FIFO is non-empty; go to HALT when the FIFO is empty and halt is latched.
  - SEND: emit the head entry's words.
  - HALT: emit the halt record.
  - DONE: done=1, tr_valid=0, held until reset.
- Word sequencing:
  - A word index counter steps 0..N-1.
  - tr_data/tr_valid are registered outputs and stay stable while tr_valid & ~tr_ready.
  - The word advances only on tr_valid & tr_ready.
  - tr_last=1 on word N-1.
  - The FIFO pops on acceptance of the last word.
- Throughput and latency:
  - With tr_ready held at 1, records go out back-to-back with no idle cycle between them.
  - First word appears one cycle after the push cycle.
- Ordering: records leave in event order, and HALT is always the final record.

Optional Feature:
- Macro TRACE_PC_EN.
- When defined:
  - Each FIFO entry also stores ev_pc.
  - Every REG/LOAD/STORE record inserts ev_pc as word 1, directly after the header.
  - Header bit 11 is set, e.g. REG header becomes 0x180r.
  - HALT record also carries the PC latched at halt as word 1.
- When undefined: formats exactly as above, header bit 11 = 0, no PC storage.

Test Plan:
- After reset, one cycle rf_we=1, rf_waddr=3, rf_wdata=0x1234, tr_ready=1 → words 0x1003, 0x1234; tr_last on the second word.
- Same cycle: rf_we (r5, 0x00AA) and mem_en=1, mem_wr=1, addr 0x0040, wdata 0xBEEF → 0x1005, 0x00AA, 0x3000, 0x0040, 0xBEEF.
- tr_ready=0 for 5 cycles while valid → tr_data stays 0x2000 stable; sequence resumes intact when tr_ready=1.
- FIFO_DEPTH=8, tr_ready=0, 10 consecutive REG-only cycles → 8 stored, drop_count=2, overflow=1; draining yields exactly 8 REG records.
- After 4 REG, 1 STORE, halt at cycle 9 → last record 0xF000, 0x0006, 0x0009; done=1 after its acceptance; later events produce no words.
- With TRACE_PC_EN, REG r2 = 0x0007 at PC 0x0010 → 0x1802, 0x0010, 0x0007.

Source files
------------

// File: rtl/commit_trace_encoder.sv
// commit_trace_encoder
//
// Commit-trace transmitter. Each cycle it samples the writeback and
// data-memory event signals, buffers REG / LOAD / STORE events in a FIFO and
// serialises them as 16-bit word records over a valid/ready stream. A halt
// latches the final instruction and cycle counts into a dedicated register.
// That HALT record is always the last record sent.
//
// Record formats (words in order, header bit 11 = PC-present flag):
//   REG   : 0x100r, wdata
//   LOAD  : 0x2000, addr, rdata
//   STORE : 0x3000, addr, wdata
//   HALT  : 0xF000, inst_count, cycle_count
// With TRACE_PC_EN defined, every record carries the event PC as word 1.
// Its header then has bit 11 set (e.g. 0x180r).
//
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   ev_pc                 PC of this cycle's events
//   rf_we/rf_waddr/rf_wdata         register writeback event
//   mem_en/mem_wr/mem_addr/mem_wdata/mem_rdata   data-memory event
//   halt                  halt reached memory/writeback stage
//   tr_data/tr_valid/tr_ready/tr_last           trace word stream
//   overflow              sticky, some event cycle was dropped
//   drop_count            dropped event cycles, saturating
//   done                  halt record fully sent
//
// Parameter FIFO_DEPTH: number of event entries, power of 2, >= 2.

module commit_trace_encoder #(
  parameter int FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] ev_pc,
  input  logic        rf_we,
  input  logic [3:0]  rf_waddr,
  input  logic [15:0] rf_wdata,
  input  logic        mem_en,
  input  logic        mem_wr,
  input  logic [15:0] mem_addr,
  input  logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata,
  input  logic        halt,
  output logic [15:0] tr_data,
  output logic        tr_valid,
  input  logic        tr_ready,
  output logic        tr_last,
  output logic        overflow,
  output logic [15:0] drop_count,
  output logic        done
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_SEND = 2'd1;
  localparam logic [1:0] S_HALT = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic [1:0] K_REG   = 2'd0;
  localparam logic [1:0] K_LOAD  = 2'd1;
  localparam logic [1:0] K_STORE = 2'd2;

`ifdef TRACE_PC_EN
  localparam logic       HDR_PC   = 1'b1;
  localparam logic [1:0] PC_WORDS = 2'd1;

  typedef struct packed {
    logic [1:0]  kind;
    logic [3:0]  rd;
    logic [15:0] addr;
    logic [15:0] data;
    logic [15:0] pc;
  } entry_t;
`else
  localparam logic       HDR_PC   = 1'b0;
  localparam logic [1:0] PC_WORDS = 2'd0;

  typedef struct packed {
    logic [1:0]  kind;
    logic [3:0]  rd;
    logic [15:0] addr;
    logic [15:0] data;
  } entry_t;
`endif

  localparam logic [15:0] HALT_HDR  = {4'hF, HDR_PC, 11'd0};
  localparam logic [1:0]  HALT_LAST = 2'd2 + PC_WORDS;

  // Word idx of a FIFO entry's record. Payload words follow the header and
  // the optional PC word: REG carries data only, LOAD/STORE carry addr, data.
  function automatic logic [15:0] entry_word(input entry_t e, input logic [1:0] idx);
    logic [15:0] w;
    logic [1:0]  j;
    w = '0;
    j = idx - 2'd1 - PC_WORDS;
    if (idx == 2'd0) begin
      case (e.kind)
        K_REG:   w = {4'h1, HDR_PC, 7'd0, e.rd};
        K_LOAD:  w = {4'h2, HDR_PC, 11'd0};
        default: w = {4'h3, HDR_PC, 11'd0};
      endcase
    end
`ifdef TRACE_PC_EN
    else if (idx == 2'd1) begin
      w = e.pc;
    end
`endif
    else begin
      w = (e.kind == K_REG || j == 2'd1) ? e.data : e.addr;
    end
    return w;
  endfunction

  function automatic logic [1:0] entry_last(input logic [1:0] kind);
    return (kind == K_REG) ? (2'd1 + PC_WORDS) : (2'd2 + PC_WORDS);
  endfunction

  // State
  entry_t             mem [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr, rd_ptr;
  logic [CNT_W-1:0]   count;
  logic [1:0]         state;
  logic [1:0]         widx;
  logic [15:0]        cycle_count, inst_count;
  logic               halt_seen;
  logic [15:0]        halt_inst, halt_cyc;
`ifdef TRACE_PC_EN
  logic [15:0]        halt_pc;
`else
  logic               pc_unused;
  assign pc_unused = ^ev_pc;
`endif

  // Per-cycle decode
  logic               accept, ev_reg, ev_mem, halt_now, halt_avail;
  logic [1:0]         n_ev, n_push;
  logic [CNT_W-1:0]   free_slots;
  logic               drop_now, inst_inc, pop, rec_end;
  entry_t             reg_entry, mem_entry, in0, in1, head, next_entry;
  logic               next_avail;
  logic [1:0]         widx_inc, hj;
  logic [15:0]        adv_word;
  logic               adv_last;

  // NOTE: every signal assigned in always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    // Once halt is latched (and in DONE) inputs are ignored entirely.
    accept     = ~halt_seen;
    ev_reg     = accept & rf_we;
    ev_mem     = accept & mem_en;
    halt_now   = accept & halt;
    halt_avail = halt_seen | halt_now;
    inst_inc   = accept & (halt | rf_we | (mem_en & mem_wr));

    n_ev       = {1'b0, ev_reg} + {1'b0, ev_mem};
    // Free space is judged on the occupancy before any pop this cycle.
    free_slots = CNT_W'(FIFO_DEPTH) - count;
    drop_now   = (CNT_W'(n_ev) > free_slots);
    n_push     = drop_now ? 2'd0 : n_ev;

    reg_entry      = '0;
    reg_entry.kind = K_REG;
    reg_entry.rd   = rf_waddr;
    reg_entry.data = rf_wdata;
    mem_entry      = '0;
    mem_entry.kind = mem_wr ? K_STORE : K_LOAD;
    mem_entry.addr = mem_addr;
    mem_entry.data = mem_wr ? mem_wdata : mem_rdata;
`ifdef TRACE_PC_EN
    reg_entry.pc   = ev_pc;
    mem_entry.pc   = ev_pc;
`endif
    // REG is pushed ahead of the memory event of the same cycle.
    in0 = ev_reg ? reg_entry : mem_entry;
    in1 = mem_entry;

    pop     = (state == S_SEND) & tr_valid & tr_ready & tr_last;
    rec_end = (state == S_IDLE) | pop;

    // Entry that starts the next record. Incoming events bypass the FIFO
    // when it holds nothing ahead of them, so a word appears the cycle after
    // the push and records follow each other without a gap.
    next_avail = 1'b0;
    next_entry = in0;
    if (pop) begin
      if (count > CNT_W'(1)) begin
        next_avail = 1'b1;
        next_entry = mem[rd_ptr + PTR_W'(1)];
      end else if (n_push != 2'd0) begin
        next_avail = 1'b1;
      end
    end else begin
      if (count != '0) begin
        next_avail = 1'b1;
        next_entry = mem[rd_ptr];
      end else if (n_push != 2'd0) begin
        next_avail = 1'b1;
      end
    end

    // Following word of the record in flight.
    head     = mem[rd_ptr];
    widx_inc = widx + 2'd1;
    hj       = widx_inc - PC_WORDS;
    adv_word = '0;
    adv_last = 1'b0;
    if (state == S_HALT) begin
      if (hj == 2'd1) adv_word = halt_inst;
      if (hj == 2'd2) adv_word = halt_cyc;
`ifdef TRACE_PC_EN
      if (widx_inc == 2'd1) adv_word = halt_pc;
`endif
      adv_last = (widx_inc == HALT_LAST);
    end else begin
      adv_word = entry_word(head, widx_inc);
      adv_last = (widx_inc == entry_last(head.kind));
    end
  end

  // NOTE: the FIFO storage has no reset; validity is tracked by the
  // pointers and count, which are reset.
  always_ff @(posedge clk) begin
    if (n_push != 2'd0) mem[wr_ptr] <= in0;
    if (n_push == 2'd2) mem[wr_ptr + PTR_W'(1)] <= in1;
  end

  // NOTE: state registers use non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      state       <= S_IDLE;
      widx        <= '0;
      cycle_count <= '0;
      inst_count  <= '0;
      halt_seen   <= 1'b0;
      halt_inst   <= '0;
      halt_cyc    <= '0;
`ifdef TRACE_PC_EN
      halt_pc     <= '0;
`endif
      tr_data     <= '0;
      tr_valid    <= 1'b0;
      tr_last     <= 1'b0;
      overflow    <= 1'b0;
      drop_count  <= '0;
      done        <= 1'b0;
    end else begin
      cycle_count <= cycle_count + 16'd1;
      if (inst_inc) inst_count <= inst_count + 16'd1;

      // The halt cycle itself counts in both totals.
      if (halt_now) begin
        halt_seen <= 1'b1;
        halt_inst <= inst_count + 16'd1;
        halt_cyc  <= cycle_count + 16'd1;
`ifdef TRACE_PC_EN
        halt_pc   <= ev_pc;
`endif
      end

      if (drop_now) begin
        overflow <= 1'b1;
        if (drop_count != 16'hFFFF) drop_count <= drop_count + 16'd1;
      end

      wr_ptr <= wr_ptr + PTR_W'(n_push);
      rd_ptr <= rd_ptr + PTR_W'(pop);
      count  <= count + CNT_W'(n_push) - CNT_W'(pop);

      if (rec_end) begin
        widx    <= '0;
        tr_last <= 1'b0;
        if (next_avail) begin
          state    <= S_SEND;
          tr_valid <= 1'b1;
          tr_data  <= entry_word(next_entry, 2'd0);
        end else if (halt_avail) begin
          state    <= S_HALT;
          tr_valid <= 1'b1;
          tr_data  <= HALT_HDR;
        end else begin
          state    <= S_IDLE;
          tr_valid <= 1'b0;
          tr_data  <= '0;
        end
      end else if ((state == S_SEND || state == S_HALT) && tr_valid && tr_ready) begin
        if (tr_last) begin
          // Only the HALT record reaches here; SEND's last word is a pop.
          state    <= S_DONE;
          done     <= 1'b1;
          tr_valid <= 1'b0;
          tr_last  <= 1'b0;
          tr_data  <= '0;
        end else begin
          widx    <= widx_inc;
          tr_data <= adv_word;
          tr_last <= adv_last;
        end
      end
    end
  end

endmodule

// File: tb/tb_commit_trace_encoder.sv
// Testbench for commit_trace_encoder: directed scenarios plus a randomized
// run, checked every cycle against a record-queue reference model.
module tb_commit_trace_encoder;

  localparam int FIFO_DEPTH = 8;
`ifdef TRACE_PC_EN
  localparam bit PC_EN = 1'b1;
`else
  localparam bit PC_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] ev_pc;
  logic        rf_we;
  logic [3:0]  rf_waddr;
  logic [15:0] rf_wdata;
  logic        mem_en, mem_wr;
  logic [15:0] mem_addr, mem_wdata, mem_rdata;
  logic        halt;
  logic [15:0] tr_data;
  logic        tr_valid, tr_ready, tr_last;
  logic        overflow, done;
  logic [15:0] drop_count;

  commit_trace_encoder #(.FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .ev_pc(ev_pc),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .halt(halt),
    .tr_data(tr_data), .tr_valid(tr_valid), .tr_ready(tr_ready),
    .tr_last(tr_last), .overflow(overflow), .drop_count(drop_count),
    .done(done)
  );

  always #5 clk = ~clk;

  // Reference model: a queue of whole expected records
  typedef struct packed {
    logic [2:0]       len;
    logic [3:0][15:0] w;
  } rec_t;

  rec_t        q[$];
  rec_t        halt_rec;
  int          widx;
  bit          halted, halt_pending, done_m, ovf_m;
  logic [15:0] cyc_m, inst_m, drop_m;

  logic [15:0] got[$];
  logic [15:0] exp_q[$];
  int          n_last;

  int n_checks = 0;
  int n_fail   = 0;

  function automatic rec_t make_rec(input logic [15:0] hdr, input logic [15:0] pc,
                                    input logic [15:0] a, input logic [15:0] b,
                                    input bit two);
    rec_t r;
    r = '0;
    r.w[0] = PC_EN ? (hdr | 16'h0800) : hdr;
    r.len  = 3'd1;
    if (PC_EN) begin
      r.w[r.len[1:0]] = pc;
      r.len = r.len + 3'd1;
    end
    r.w[r.len[1:0]] = a;
    r.len = r.len + 3'd1;
    if (two) begin
      r.w[r.len[1:0]] = b;
      r.len = r.len + 3'd1;
    end
    return r;
  endfunction

  task automatic check(input string tag, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    assert (act === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, act, exp);
    end
  endtask

  task automatic idle_inputs();
    rf_we = 0; rf_waddr = 0; rf_wdata = 0; mem_en = 0; mem_wr = 0;
    mem_addr = 0; mem_wdata = 0; mem_rdata = 0; halt = 0; ev_pc = 0;
  endtask

  // One clock cycle: check outputs against the model, advance the model with
  // this cycle's inputs, then move to just after the next rising edge.
  task automatic tick();
    rec_t cur;
    bit   has;
    int   free, n;
    has = 0;
    cur = '0;
    if (q.size() > 0) begin cur = q[0]; has = 1; end
    else if (halt_pending) begin cur = halt_rec; has = 1; end

    check("tr_valid", 16'(tr_valid), 16'(has));
    if (has) begin
      check("tr_data", tr_data, cur.w[widx]);
      check("tr_last", 16'(tr_last), 16'(widx == int'(cur.len) - 1));
    end
    check("overflow", 16'(overflow), 16'(ovf_m));
    check("drop_count", drop_count, drop_m);
    check("done", 16'(done), 16'(done_m));

    if (has && tr_ready) begin
      got.push_back(tr_data);
      if (tr_last) n_last++;
    end

    free = FIFO_DEPTH - q.size();
    if (has && tr_ready) begin
      if (widx == int'(cur.len) - 1) begin
        widx = 0;
        if (q.size() > 0) void'(q.pop_front());
        else begin halt_pending = 0; done_m = 1; end
      end else begin
        widx++;
      end
    end

    cyc_m = cyc_m + 16'd1;
    if (!halted) begin
      n = int'(rf_we) + int'(mem_en);
      if (halt || rf_we || (mem_en && mem_wr)) inst_m = inst_m + 16'd1;
      if (n > free) begin
        ovf_m = 1;
        if (drop_m != 16'hFFFF) drop_m = drop_m + 16'd1;
      end else begin
        if (rf_we) q.push_back(make_rec(16'h1000 | 16'(rf_waddr), ev_pc, rf_wdata, 16'h0, 0));
        if (mem_en) begin
          if (mem_wr) q.push_back(make_rec(16'h3000, ev_pc, mem_addr, mem_wdata, 1));
          else        q.push_back(make_rec(16'h2000, ev_pc, mem_addr, mem_rdata, 1));
        end
      end
      if (halt) begin
        halted = 1;
        halt_pending = 1;
        halt_rec = make_rec(16'hF000, ev_pc, inst_m, cyc_m, 1);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic reset_dut();
    rst_n = 0;
    idle_inputs();
    @(posedge clk);
    @(posedge clk);
    #1;
    q.delete(); got.delete(); widx = 0; n_last = 0;
    halted = 0; halt_pending = 0; done_m = 0; ovf_m = 0;
    cyc_m = 0; inst_m = 0; drop_m = 0;
    check("rst_tr_valid", 16'(tr_valid), 16'h0);
    check("rst_tr_data", tr_data, 16'h0);
    check("rst_tr_last", 16'(tr_last), 16'h0);
    check("rst_overflow", 16'(overflow), 16'h0);
    check("rst_drop_count", drop_count, 16'h0);
    check("rst_done", 16'(done), 16'h0);
    rst_n = 1;
  endtask

  task automatic check_log(input string tag);
    check({tag, "_len"}, 16'(got.size()), 16'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got.size(); i++) check(tag, got[i], exp_q[i]);
  endtask

  initial begin
    rst_n = 0;
    tr_ready = 1;
    idle_inputs();

    // Single REG record
    reset_dut();
    tr_ready = 1;
`ifdef TRACE_PC_EN
    rf_we = 1; rf_waddr = 4'd2; rf_wdata = 16'h0007; ev_pc = 16'h0010;
    tick();
    idle_inputs();
    repeat (5) tick();
    exp_q = {16'h1802, 16'h0010, 16'h0007};
`else
    rf_we = 1; rf_waddr = 4'd3; rf_wdata = 16'h1234;
    tick();
    idle_inputs();
    repeat (5) tick();
    exp_q = {16'h1003, 16'h1234};
`endif
    check_log("reg_record");
    check("reg_record_lasts", 16'(n_last), 16'd1);

    // REG and STORE in the same cycle
    got.delete(); n_last = 0;
    rf_we = 1; rf_waddr = 4'd5; rf_wdata = 16'h00AA; ev_pc = 16'h0020;
    mem_en = 1; mem_wr = 1; mem_addr = 16'h0040; mem_wdata = 16'hBEEF;
    tick();
    idle_inputs();
    repeat (8) tick();
`ifdef TRACE_PC_EN
    exp_q = {16'h1805, 16'h0020, 16'h00AA, 16'h3800, 16'h0020, 16'h0040, 16'hBEEF};
`else
    exp_q = {16'h1005, 16'h00AA, 16'h3000, 16'h0040, 16'hBEEF};
`endif
    check_log("reg_store");

    // LOAD held under back-pressure
    got.delete();
    tr_ready = 0;
    mem_en = 1; mem_wr = 0; mem_addr = 16'h0077; mem_rdata = 16'h5555;
    tick();
    idle_inputs();
    for (int i = 0; i < 5; i++) begin
      check("stall_data", tr_data, PC_EN ? 16'h2800 : 16'h2000);
      tick();
    end
    tr_ready = 1;
    repeat (6) tick();
    check("stall_words", 16'(got.size()), PC_EN ? 16'd4 : 16'd3);

    // Overflow: ten REG cycles into an eight-entry FIFO
    reset_dut();
    tr_ready = 0;
    for (int i = 0; i < 10; i++) begin
      rf_we = 1; rf_waddr = 4'(i); rf_wdata = 16'($urandom); ev_pc = 16'(i);
      tick();
    end
    idle_inputs();
    check("ovf_drop_count", drop_count, 16'd2);
    check("ovf_overflow", 16'(overflow), 16'd1);
    tr_ready = 1;
    repeat (30) tick();
    check("ovf_records", 16'(n_last), 16'd8);

    // Randomized traffic with random back-pressure
    reset_dut();
    for (int i = 0; i < 400; i++) begin
      rf_we     = ($urandom_range(0, 99) < 45);
      rf_waddr  = 4'($urandom);
      rf_wdata  = 16'($urandom);
      mem_en    = ($urandom_range(0, 99) < 40);
      mem_wr    = 1'($urandom);
      mem_addr  = 16'($urandom);
      mem_wdata = 16'($urandom);
      mem_rdata = 16'($urandom);
      ev_pc     = 16'($urandom);
      tr_ready  = ($urandom_range(0, 99) < 70);
      tick();
    end
    idle_inputs();
    tr_ready = 1;
    repeat (40) tick();
    check("rand_drained", 16'(q.size()), 16'd0);

    // Reset in the middle of a record
    reset_dut();
    tr_ready = 0;
    mem_en = 1; mem_wr = 1; mem_addr = 16'h1111; mem_wdata = 16'h2222;
    tick();
    idle_inputs();
    tick();
    reset_dut();
    tr_ready = 1;
    repeat (4) tick();
    check("midrst_words", 16'(got.size()), 16'd0);

    // Halt: 4 REG, 1 STORE, halt at cycle 9
    reset_dut();
    tr_ready = 1;
    for (int c = 1; c <= 9; c++) begin
      idle_inputs();
      ev_pc = 16'(c * 2);
      if (c <= 4) begin rf_we = 1; rf_waddr = 4'(c); rf_wdata = 16'h0100 + 16'(c); end
      if (c == 5) begin mem_en = 1; mem_wr = 1; mem_addr = 16'h0080; mem_wdata = 16'hCAFE; end
      if (c == 9) halt = 1;
      tick();
    end
    idle_inputs();
    repeat (20) tick();
    check("halt_words", 16'(got.size()), PC_EN ? 16'd20 : 16'd14);
    if (got.size() >= 3) begin
      check("halt_inst", got[got.size() - 2], 16'h0006);
      check("halt_cyc", got[got.size() - 1], 16'h0009);
    end else begin
      check("halt_tail_present", 16'(got.size()), 16'd3);
    end
    check("halt_done", 16'(done), 16'd1);
    for (int i = 0; i < 10; i++) begin
      rf_we = 1; rf_waddr = 4'(i); rf_wdata = 16'($urandom);
      mem_en = 1; mem_wr = 1'($urandom); halt = 1'($urandom);
      tick();
    end
    idle_inputs();
    repeat (3) tick();
    check("post_halt_words", 16'(got.size()), PC_EN ? 16'd20 : 16'd14);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
